// File: rtl/alu_pipe.sv
// alu_pipe: handshaked eight-operation ALU with an iterative shift-add multiply
// and a single output holding register that absorbs downstream back-pressure.
module alu_pipe #(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        opcode,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [IMM_W-1:0]  immediate,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_out,
  output logic              out_zero,
  output logic              out_ovf
);
  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_NOT = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [0:0] {IDLE = 1'b0, MUL = 1'b1} state_t;

  state_t              state_r, state_next_s;
  logic [CNT_W-1:0]    cnt_r, cnt_next_s;
  logic [2*DATA_W-1:0] acc_r, acc_next_s;
  logic [2*DATA_W-1:0] mcand_r, mcand_next_s;
  logic [DATA_W-1:0]   mplier_r, mplier_next_s;
  logic [2*DATA_W-1:0] acc_step_s;

  logic                out_valid_r, out_zero_r, out_ovf_r;
  logic [DATA_W-1:0]   alu_out_r;

  logic                accept_s, load_s, ovf_s, op_ovf_s, shift_big_s;
  logic [DATA_W-1:0]   res_s, op_res_s, sum_s, diff_s;

  assign in_ready  = (state_r == IDLE) && (!out_valid_r || out_ready);
  assign accept_s  = in_valid && in_ready;
  assign out_valid = out_valid_r;
  assign alu_out   = alu_out_r;
  assign out_zero  = out_zero_r;
  assign out_ovf   = out_ovf_r;

  // Single-cycle datapath for every non-MUL opcode.
  always_comb begin
    sum_s       = rs_data + rt_data;
    diff_s      = rs_data - rt_data;
    shift_big_s = (32'(immediate) >= 32'(DATA_W));
    op_res_s    = '0;
    op_ovf_s    = 1'b0;
    case (opcode)
      OP_ADD: begin
        op_res_s = sum_s;
        op_ovf_s = (rs_data[DATA_W-1] == rt_data[DATA_W-1]) &&
                   (sum_s[DATA_W-1] != rs_data[DATA_W-1]);
      end
      OP_SUB: begin
        op_res_s = diff_s;
        op_ovf_s = (rs_data[DATA_W-1] != rt_data[DATA_W-1]) &&
                   (diff_s[DATA_W-1] != rs_data[DATA_W-1]);
      end
      OP_AND: op_res_s = rs_data & rt_data;
      OP_OR:  op_res_s = rs_data | rt_data;
      OP_NOT: op_res_s = ~rs_data;
      OP_SLL: op_res_s = shift_big_s ? '0 : (rs_data << immediate);
      OP_SRL: op_res_s = shift_big_s ? '0 : (rs_data >> immediate);
      default: op_res_s = '0;
    endcase
  end

  // One shift-add step: add the multiplicand when the multiplier LSB is set.
  always_comb begin
    if (mplier_r[0]) begin
      acc_step_s = acc_r + mcand_r;
    end else begin
      acc_step_s = acc_r;
    end
  end

  // Next-state logic and output-register load control.
  always_comb begin
    state_next_s  = state_r;
    cnt_next_s    = cnt_r;
    acc_next_s    = acc_r;
    mcand_next_s  = mcand_r;
    mplier_next_s = mplier_r;
    load_s        = 1'b0;
    res_s         = op_res_s;
    ovf_s         = op_ovf_s;
    case (state_r)
      IDLE: begin
        if (accept_s && (opcode == OP_MUL)) begin
          state_next_s  = MUL;
          cnt_next_s    = CNT_W'(DATA_W);
          acc_next_s    = '0;
          mcand_next_s  = {{DATA_W{1'b0}}, rs_data};
          mplier_next_s = rt_data;
        end else begin
          load_s = accept_s;
        end
      end
      MUL: begin
        acc_next_s    = acc_step_s;
        mcand_next_s  = mcand_r << 1;
        mplier_next_s = mplier_r >> 1;
        cnt_next_s    = cnt_r - CNT_W'(1);
        // Last iteration: the final accumulator goes straight to the output slot.
        if (cnt_r == CNT_W'(1)) begin
          state_next_s = IDLE;
          load_s       = 1'b1;
          res_s        = acc_step_s[DATA_W-1:0];
          ovf_s        = |acc_step_s[2*DATA_W-1:DATA_W];
        end else begin
          state_next_s = MUL;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM and multiplier datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      acc_r    <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
    end else begin
      state_r  <= state_next_s;
      cnt_r    <= cnt_next_s;
      acc_r    <= acc_next_s;
      mcand_r  <= mcand_next_s;
      mplier_r <= mplier_next_s;
    end
  end

  // Output holding register; a same-edge load wins over consumption.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      alu_out_r   <= '0;
      out_zero_r  <= 1'b0;
      out_ovf_r   <= 1'b0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      alu_out_r   <= res_s;
      out_zero_r  <= (res_s == '0);
      out_ovf_r   <= ovf_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: table-driven single-cycle vectors plus hand-written MUL,
// back-pressure and mid-MUL reset sequences for alu_pipe.
module tb_alu_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  opcode;
  logic [15:0] rs_data;
  logic [15:0] rt_data;
  logic [4:0]  immediate;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] alu_out;
  logic        out_zero;
  logic        out_ovf;

  int total = 0;
  int bad   = 0;

  alu_pipe #(.DATA_W(16), .IMM_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rs_data(rs_data), .rt_data(rt_data), .immediate(immediate),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_out(alu_out), .out_zero(out_zero), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [4:0]  imm;
    logic [15:0] res;
    logic        z;
    logic        v;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [4:0] imm);
    in_valid  = v;
    opcode    = op;
    rs_data   = a;
    rt_data   = b;
    immediate = imm;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic [15:0] res, input logic z, input logic v);
    check({name, ".valid"}, 32'(out_valid), 32'd1);
    check({name, ".out"},   32'(alu_out),   32'(res));
    check({name, ".zero"},  32'(out_zero),  32'(z));
    check({name, ".ovf"},   32'(out_ovf),   32'(v));
  endtask

  initial begin
    int cyc;
    int rdy_hi;
    int vld_hi;

    vecs[0]  = '{3'd0, 16'h7FFF, 16'h0001, 5'd0,  16'h8000, 1'b0, 1'b1};
    vecs[1]  = '{3'd1, 16'h0005, 16'h0005, 5'd0,  16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{3'd2, 16'hF0F0, 16'h0FF0, 5'd0,  16'h00F0, 1'b0, 1'b0};
    vecs[3]  = '{3'd3, 16'hF000, 16'h000F, 5'd0,  16'hF00F, 1'b0, 1'b0};
    vecs[4]  = '{3'd4, 16'h00FF, 16'h1234, 5'd0,  16'hFF00, 1'b0, 1'b0};
    vecs[5]  = '{3'd5, 16'h0001, 16'h0000, 5'd15, 16'h8000, 1'b0, 1'b0};
    vecs[6]  = '{3'd5, 16'h0001, 16'h0000, 5'd16, 16'h0000, 1'b1, 1'b0};
    vecs[7]  = '{3'd6, 16'h8000, 16'h0000, 5'd31, 16'h0000, 1'b1, 1'b0};
    vecs[8]  = '{3'd6, 16'hF000, 16'h0000, 5'd4,  16'h0F00, 1'b0, 1'b0};
    vecs[9]  = '{3'd0, 16'hFFFF, 16'h0001, 5'd0,  16'h0000, 1'b1, 1'b0};
    vecs[10] = '{3'd1, 16'h8000, 16'h0001, 5'd0,  16'h7FFF, 1'b0, 1'b1};
    vecs[11] = '{3'd1, 16'h0000, 16'h0001, 5'd0,  16'hFFFF, 1'b0, 1'b0};
    vecs[12] = '{3'd0, 16'h8000, 16'h8000, 5'd0,  16'h0000, 1'b1, 1'b1};

    rst       = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 3'd0, 16'h0000, 16'h0000, 5'd0);
    #2;
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.out",   32'(alu_out),   32'd0);
    check("rst.zero",  32'(out_zero),  32'd0);
    check("rst.ovf",   32'(out_ovf),   32'd0);
    step();
    rst = 1'b0;
    #1;
    check("rst.in_ready", 32'(in_ready), 32'd1);

    // Back-to-back single-cycle stream with the consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm);
      check($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'd1);
      step();
      check_out($sformatf("vec%0d", i), vecs[i].res, vecs[i].z, vecs[i].v);
    end
    drive(1'b0, 3'd0, 16'h0000, 16'h0000, 5'd0);
    step();
    check("drain.valid", 32'(out_valid), 32'd0);

    // MUL 3x5: result exactly 16 cycles after accept, in_ready low meanwhile.
    drive(1'b1, 3'd7, 16'h0003, 16'h0005, 5'd0);
    step();
    drive(1'b0, 3'd0, 16'hDEAD, 16'hBEEF, 5'd0);
    cyc = 0;
    rdy_hi = 0;
    while (!out_valid && cyc < 40) begin
      if (in_ready) rdy_hi++;
      step();
      cyc++;
    end
    check("mul1.latency", 32'(cyc), 32'd16);
    check("mul1.in_ready_busy", 32'(rdy_hi), 32'd0);
    check_out("mul1", 16'h000F, 1'b0, 1'b0);
    check("mul1.in_ready_done", 32'(in_ready), 32'd1);

    // Second MUL accepted right on the completion cycle.
    drive(1'b1, 3'd7, 16'h0100, 16'h0100, 5'd0);
    step();
    drive(1'b0, 3'd0, 16'h0000, 16'h0000, 5'd0);
    check("mul2.slot_empty", 32'(out_valid), 32'd0);
    cyc = 0;
    rdy_hi = 0;
    while (!out_valid && cyc < 40) begin
      if (in_ready) rdy_hi++;
      step();
      cyc++;
    end
    check("mul2.latency", 32'(cyc), 32'd16);
    check("mul2.in_ready_busy", 32'(rdy_hi), 32'd0);
    check_out("mul2", 16'h0000, 1'b1, 1'b1);
    step();
    check("mul2.consumed", 32'(out_valid), 32'd0);

    // Back-pressure: ADD 1+2 held while SUB 9-4 waits at the input.
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 16'h0001, 16'h0002, 5'd0);
    check("bp.accept_ready", 32'(in_ready), 32'd1);
    step();
    drive(1'b1, 3'd1, 16'h0009, 16'h0004, 5'd0);
    for (int i = 0; i < 5; i++) begin
      check_out($sformatf("bp.hold%0d", i), 16'h0003, 1'b0, 1'b0);
      check($sformatf("bp.in_ready%0d", i), 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp.release_ready", 32'(in_ready), 32'd1);
    step();
    drive(1'b0, 3'd0, 16'h0000, 16'h0000, 5'd0);
    check_out("bp.sub", 16'h0005, 1'b0, 1'b0);
    step();
    check("bp.drained", 32'(out_valid), 32'd0);

    // Reset during cycle 7 of a MUL: outputs clear at once, no result follows.
    drive(1'b1, 3'd7, 16'h1234, 16'h0002, 5'd0);
    step();
    drive(1'b0, 3'd0, 16'h0000, 16'h0000, 5'd0);
    repeat (6) step();
    rst = 1'b1;
    #1;
    check("abort.valid", 32'(out_valid), 32'd0);
    check("abort.out",   32'(alu_out),   32'd0);
    check("abort.zero",  32'(out_zero),  32'd0);
    check("abort.ovf",   32'(out_ovf),   32'd0);
    step();
    rst = 1'b0;
    #1;
    check("abort.in_ready", 32'(in_ready), 32'd1);
    vld_hi = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid) vld_hi++;
    end
    check("abort.no_pulse", 32'(vld_hi), 32'd0);

    drive(1'b1, 3'd0, 16'h0002, 16'h0002, 5'd0);
    step();
    drive(1'b0, 3'd0, 16'h0000, 16'h0000, 5'd0);
    check_out("post_rst.add", 16'h0004, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the 16-bit combinational ALU. It takes opcode, rs, rt and immediate operands through a valid/ready input port and returns a registered result plus zero/overflow flags through a valid/ready output port. Single-cycle ops have a one-cycle latency. MUL is an iterative shift-add multiply that takes DATA_W cycles. The block sits between the register-read stage and write-back, and absorbs downstream back-pressure through a single output holding register.

## Interface
- DATA_W, 16, operand/result width (≥4)
- IMM_W, 5, immediate (shift amount) width

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand bundle valid
- in_ready  out  1  block accepts bundle this cycle
- opcode  in  3  operation select
- rs_data  in  DATA_W  operand A
- rt_data  in  DATA_W  operand B
- immediate  in  IMM_W  shift amount (unsigned)
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result this cycle
- alu_out  out  DATA_W  result
- out_zero  out  1  alu_out == 0
- out_ovf  out  1  overflow flag (see below)

## Operation
- Opcodes:
  - 0 ADD: rs+rt
  - 1 SUB: rs−rt
  - 2 AND
  - 3 OR
  - 4 NOT: ~rs
  - 5 SLL: rs << immediate
  - 6 SRL: logical rs >> immediate
  - 7 MUL: low DATA_W bits of the unsigned rs×rt
- Results wrap modulo 2^DATA_W.
- Shift amount ≥ DATA_W gives 0.
- out_ovf:
  - ADD/SUB: signed two's-complement overflow.
  - MUL: upper DATA_W bits of the 2·DATA_W product are nonzero.
  - All other ops: 0.
- out_zero is computed from the final result for every op.
- Accept occurs when in_valid && in_ready at a rising edge. All operands are captured at that edge. Inputs are don't-care afterwards.
- in_ready = (state==IDLE) && (!out_valid || out_ready). It is combinational from state/out_valid/out_ready only, with no dependence on in_valid.
- States:
  - IDLE
    - Non-MUL accept: load the output register, set out_valid, stay in IDLE.
    - MUL accept: latch operands, clear the accumulator, load counter = DATA_W, go to MUL.
  - MUL
    - Each cycle: if multiplier LSB, accumulator += multiplicand (2·DATA_W wide). Then shift the multiplicand left and the multiplier right, and decrement the counter.
    - When the counter reaches 0, load the output register with the low half and the flags, set out_valid, and return to IDLE.
    - in_ready = 0 throughout.
- Output register:
  - Holds alu_out/flags stable while out_valid && !out_ready.
  - out_valid clears on out_ready unless a new result loads the same edge.
  - Simultaneous consume and non-MUL accept: the new result replaces the old one and out_valid stays 1.
- The output slot is empty whenever MUL is in progress. MUL completion never blocks.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, counter=0, accumulator=0.
  - out_valid=0, alu_out=0, out_zero=0, out_ovf=0.
  - in_ready=1 after reset deasserts.
- Non-MUL latency: accepted at edge k, result visible with out_valid=1 after edge k.
- MUL latency: accepted at edge k, out_valid=1 after edge k+DATA_W. in_ready=0 from after edge k until the cycle after completion (given out_ready).
- Throughput:
  - Non-MUL ops: 1 per cycle while out_ready=1.
  - MUL: 1 per DATA_W+1 cycles.
- Reset asserted mid-MUL aborts the operation. No result is produced.
- out_ready without out_valid is ignored.

## Test plan
- Reset, then ADD 0x7FFF+0x0001 → next cycle alu_out=0x8000, out_ovf=1, out_zero=0. Then SUB 0x0005−0x0005 → 0x0000, out_zero=1, out_ovf=0.
- Back-to-back stream with out_ready=1: AND 0xF0F0&0x0FF0, OR 0xF000|0x000F, NOT 0x00FF on three consecutive cycles → 0x00F0, 0xF00F, 0xFF00 on three consecutive cycles, with in_ready held 1.
- Shifts: SLL 0x0001 by 15 → 0x8000; SLL by 16 → 0x0000 with out_zero=1; SRL 0x8000 by 31 → 0x0000; SRL 0xF000 by 4 → 0x0F00.
- MUL 0x0003×0x0005:
  - out_valid exactly 16 cycles after accept, alu_out=0x000F, out_ovf=0.
  - MUL 0x0100×0x0100 → alu_out=0x0000, out_zero=1, out_ovf=1.
  - in_ready=0 during both.
- Back-pressure: hold out_ready=0 after ADD 1+2 → alu_out=0x0003 stable and in_ready=0 for 5 cycles. Raise out_ready with a pending SUB 9−4 → both transfers happen and 0x0005 appears next cycle.
- Assert rst at cycle 7 of a MUL → all outputs 0 immediately, no out_valid pulse. A following ADD 2+2 → 0x0004 with normal one-cycle latency.
